riscv_v_rf_mp: RTL and testbench

Parametrised multi-read-port vector register file with byte-enabled writes, optional write-to-read bypass and a multi-cycle register-group clear engine. It is the next-generation operand store for the vector datapath: reads feed the lane ALUs, the single write port takes writeback, and the clear engine zeroes LMUL register groups for vector-unit init and context switch. A synthesis debug read port is retained.

---
 rtl/riscv_v_rf_mp.sv | 155 +++++++++++++++
 tb/tb_riscv_v_rf_mp.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_rf_mp.sv
// Multi-read-port vector register file with byte-enabled writeback, optional
// write-to-read bypass and a sequential register-group clear engine.
module riscv_v_rf_mp #(
  parameter int VLEN         = 128,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int RD_ASYNC     = 1,
  parameter int RD_BYPASS    = 1,
  localparam int NB          = VLEN / 8,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NB-1:0]                wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [VLEN-1:0]              wr_data,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
  output logic [NUM_RD_PORTS*VLEN-1:0] rd_data,
  input  logic                         clr_req,
  input  logic [AW-1:0]                clr_base,
  input  logic [3:0]                   clr_num,
  output logic                         clr_busy,
  output logic                         clr_done,
  input  logic [AW-1:0]                syn_addr,
  output logic [VLEN-1:0]              syn_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      num_sat;
  logic            clr_wr;

  logic [VLEN-1:0] regs_q [NUM_REGS];
  logic [VLEN-1:0] regs_d [NUM_REGS];

  assign num_sat  = (clr_num > 4'd8) ? 4'd8 : clr_num;
  assign clr_wr   = (state_q == S_CLEAR);
  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          if (clr_num != 4'd0) begin
            ptr_d   = clr_base;
            cnt_d   = num_sat;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        // ptr wraps naturally because NUM_REGS is a power of two
        ptr_d = ptr_q + AW'(1);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear is applied first so an external write to the same register wins per byte.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (clr_wr && (ptr_q == AW'(r))) begin
        regs_d[r] = '0;
      end
      if (wr_addr == AW'(r)) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_en[b]) begin
            regs_d[r][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign syn_data = regs_q[syn_addr];

  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [VLEN-1:0] val;

    assign addr = rd_addr[gi*AW +: AW];

    // Only the external write port is forwarded; clear-engine zeroing never is.
    always_comb begin
      val = regs_q[addr];
      if ((RD_BYPASS != 0) && (addr == wr_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_en[b]) begin
            val[8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end

    if (RD_ASYNC != 0) begin : g_async
      assign rd_data[gi*VLEN +: VLEN] = val;
    end else begin : g_sync
      logic [VLEN-1:0] rd_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else begin
          rd_q <= val;
        end
      end
      assign rd_data[gi*VLEN +: VLEN] = rd_q;
    end
  end

endmodule

// File: tb/tb_riscv_v_rf_mp.sv
// Directed bench for riscv_v_rf_mp: three read configurations share one stimulus
// stream; expected values are queued at drive time and popped at the sample point.
module tb_riscv_v_rf_mp;
  localparam int VLEN = 128;
  localparam int NR   = 32;
  localparam int NP   = 2;
  localparam int NB   = VLEN / 8;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NB-1:0]     wr_en;
  logic [AW-1:0]     wr_addr;
  logic [VLEN-1:0]   wr_data;
  logic [NP*AW-1:0]  rd_addr;
  logic              clr_req;
  logic [AW-1:0]     clr_base;
  logic [3:0]        clr_num;
  logic [AW-1:0]     syn_addr;

  logic [NP*VLEN-1:0] rd_data_a, rd_data_b, rd_data_c;
  logic               clr_busy_a, clr_busy_b, clr_busy_c;
  logic               clr_done_a, clr_done_b, clr_done_c;
  logic [VLEN-1:0]    syn_data_a, syn_data_b, syn_data_c;

  always #5 clk = ~clk;

  // a: async + bypass, b: registered + bypass, c: async without bypass
  riscv_v_rf_mp #(.VLEN(VLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .RD_ASYNC(1), .RD_BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .clr_req(clr_req), .clr_base(clr_base),
    .clr_num(clr_num), .clr_busy(clr_busy_a), .clr_done(clr_done_a),
    .syn_addr(syn_addr), .syn_data(syn_data_a));

  riscv_v_rf_mp #(.VLEN(VLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .RD_ASYNC(0), .RD_BYPASS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .clr_req(clr_req), .clr_base(clr_base),
    .clr_num(clr_num), .clr_busy(clr_busy_b), .clr_done(clr_done_b),
    .syn_addr(syn_addr), .syn_data(syn_data_b));

  riscv_v_rf_mp #(.VLEN(VLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .RD_ASYNC(1), .RD_BYPASS(0)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_c), .clr_req(clr_req), .clr_base(clr_base),
    .clr_num(clr_num), .clr_busy(clr_busy_c), .clr_done(clr_done_c),
    .syn_addr(syn_addr), .syn_data(syn_data_c));

  typedef struct {
    string           tag;
    logic [VLEN-1:0] exp;
  } sb_t;

  sb_t             sb_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [VLEN-1:0] model [NR];

  task automatic push(input string tag, input logic [VLEN-1:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [VLEN-1:0] obs);
    sb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h, required a queued entry", obs);
      return;
    end
    e = sb_q.pop_front();
    $display("check %-22s observed %h expected %h", e.tag, obs, e.exp);
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic model_wr(input logic [AW-1:0] a, input logic [NB-1:0] e, input logic [VLEN-1:0] d);
    for (int b = 0; b < NB; b++) begin
      if (e[b]) model[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic wr_cycle(input logic [AW-1:0] a, input logic [NB-1:0] e, input logic [VLEN-1:0] d);
    wr_addr = a;
    wr_en   = e;
    wr_data = d;
    cyc();
    model_wr(a, e, d);
    wr_en = '0;
  endtask

  task automatic peek(input logic [AW-1:0] a, input string tag);
    syn_addr = a;
    #1;
    push(tag, model[a]);
    chk(syn_data_a);
  endtask

  // Called in the first cycle after the request edge; counts busy cycles until done.
  task automatic wait_done(input int exp_busy, input string tag);
    int busy_n = 0;
    bit seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (clr_done_a) begin
        seen = 1'b1;
        break;
      end
      if (clr_busy_a) busy_n++;
      cyc();
    end
    push({tag, "_done_seen"}, 1);
    chk(VLEN'(seen));
    push({tag, "_busy_cycles"}, VLEN'(exp_busy));
    chk(VLEN'(busy_n));
    push({tag, "_busy_in_done"}, 0);
    chk(VLEN'(clr_busy_a));
    cyc();
    push({tag, "_done_one_cycle"}, 0);
    chk(VLEN'(clr_done_a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0] pat, ones, mix, a5, coll_d;
    int              dn;

    rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    clr_req = 1'b0; clr_base = '0; clr_num = '0; syn_addr = '0;
    for (int r = 0; r < NR; r++) model[r] = '0;
    for (int b = 0; b < NB; b++) pat[8*b +: 8] = 8'(b);
    ones   = '1;
    mix    = {{15{8'hFF}}, 8'h00};
    a5     = {16{8'hA5}};
    coll_d = {{14{8'hEE}}, 16'h1234};

    // reset state
    repeat (2) cyc();
    mid();
    push("rst_rd_async", 0);  chk(rd_data_a[0 +: VLEN]);
    push("rst_rd_sync", 0);   chk(rd_data_b[0 +: VLEN]);
    push("rst_busy", 0);      chk(VLEN'(clr_busy_a));
    push("rst_done", 0);      chk(VLEN'(clr_done_a));
    cyc();
    rst_n = 1'b1;
    cyc();

    // full write of reg3 with same-cycle reads
    rd_addr = {5'd5, 5'd3};
    wr_addr = 5'd3; wr_en = '1; wr_data = pat; syn_addr = 5'd3;
    mid();
    push("bypass_async_p0", pat); chk(rd_data_a[0 +: VLEN]);
    push("nobypass_old_p0", 0);   chk(rd_data_c[0 +: VLEN]);
    push("sync_latency_p0", 0);   chk(rd_data_b[0 +: VLEN]);
    push("syn_not_bypassed", 0);  chk(syn_data_a);
    cyc();
    model_wr(5'd3, '1, pat);
    wr_en = '0;
    mid();
    push("sync_next_p0", pat);     chk(rd_data_b[0 +: VLEN]);
    push("nobypass_new_p0", pat);  chk(rd_data_c[0 +: VLEN]);
    push("port1_reg5_zero", 0);    chk(rd_data_a[VLEN +: VLEN]);
    cyc();

    // byte enables on reg5
    wr_cycle(5'd5, '1, ones);
    wr_addr = 5'd5; wr_en = 16'h0001; wr_data = '0;
    mid();
    push("bypass_partial_p1", mix); chk(rd_data_a[VLEN +: VLEN]);
    push("nobypass_p1", ones);      chk(rd_data_c[VLEN +: VLEN]);
    push("port0_reg3", pat);        chk(rd_data_a[0 +: VLEN]);
    cyc();
    model_wr(5'd5, 16'h0001, '0);
    wr_en = '0;
    mid();
    push("bytemask_async_p1", mix); chk(rd_data_a[VLEN +: VLEN]);
    push("bytemask_sync_p1", mix);  chk(rd_data_b[VLEN +: VLEN]);
    cyc();

    // bypass of reg7
    rd_addr = {5'd5, 5'd7};
    wr_addr = 5'd7; wr_en = '1; wr_data = a5;
    mid();
    push("bypass_a5_p0", a5);   chk(rd_data_a[0 +: VLEN]);
    push("nobypass_a5_old", 0); chk(rd_data_c[0 +: VLEN]);
    cyc();
    model_wr(5'd7, '1, a5);
    wr_en = '0;
    mid();
    push("nobypass_a5_new", a5); chk(rd_data_c[0 +: VLEN]);
    cyc();

    // fill every register, then clear 30,31,0,1 with a wrap
    for (int r = 0; r < NR; r++) wr_cycle(AW'(r), '1, {16{8'(r) + 8'h11}});
    rd_addr = {5'd2, 5'd30};
    clr_base = 5'd30; clr_num = 4'd4; clr_req = 1'b1;
    cyc();
    clr_base = 5'd10; clr_num = 4'd2;
    syn_addr = 5'd30;
    mid();
    push("clr_busy_first", 1);       chk(VLEN'(clr_busy_a));
    push("clr_preclear_rd", model[30]); chk(rd_data_a[0 +: VLEN]);
    push("clr_preclear_syn", model[30]); chk(syn_data_a);
    cyc();
    clr_req = 1'b0;
    wait_done(3, "clr_wrap");
    model[30] = '0; model[31] = '0; model[0] = '0; model[1] = '0;
    peek(5'd30, "wrap_reg30");
    peek(5'd31, "wrap_reg31");
    peek(5'd0,  "wrap_reg0");
    peek(5'd1,  "wrap_reg1");
    peek(5'd2,  "wrap_reg2_kept");
    peek(5'd10, "ignored_req_reg10");
    cyc();

    // write collision with the clear pointer
    clr_base = 5'd8; clr_num = 4'd1; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    wr_addr = 5'd8; wr_en = 16'h0003; wr_data = coll_d;
    cyc();
    wr_en = '0;
    model[8] = '0;
    model_wr(5'd8, 16'h0003, coll_d);
    mid();
    push("collision_done", 1); chk(VLEN'(clr_done_a));
    syn_addr = 5'd8;
    #1;
    push("collision_reg8", 128'h1234); chk(syn_data_a);
    cyc();

    // zero-length clear
    clr_base = 5'd20; clr_num = 4'd0; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    wait_done(0, "clr_zero");
    peek(5'd20, "clr_zero_reg20");
    cyc();

    // clr_num saturates at 8
    clr_base = 5'd16; clr_num = 4'hF; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    wait_done(8, "clr_sat");
    for (int r = 16; r < 24; r++) model[r] = '0;
    peek(5'd16, "sat_reg16");
    peek(5'd23, "sat_reg23");
    peek(5'd24, "sat_reg24_kept");
    cyc();

    // asynchronous reset in the middle of a clear
    clr_base = 5'd12; clr_num = 4'd6; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    cyc();
    cyc();
    #1;
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < NR; r++) model[r] = '0;
    push("rst_mid_busy", 0); chk(VLEN'(clr_busy_a));
    push("rst_mid_done", 0); chk(VLEN'(clr_done_a));
    peek(5'd25, "rst_mid_reg25");
    cyc();
    cyc();
    rst_n = 1'b1;
    dn = 0;
    repeat (4) begin
      mid();
      dn += int'(clr_done_a);
      cyc();
    end
    push("rst_no_done", 0); chk(VLEN'(dn));
    clr_base = 5'd0; clr_num = 4'd2; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    wait_done(2, "clr_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
